// File: rtl/ofdm_adc_capture_pkg.sv
// Shared types and helpers for the OFDM ADC capture path: beat layout, FSM states,
// and offset-binary to two's-complement conversion.
package ofdm_pkg;

    localparam int DATA_W   = 38;
    localparam int ENTRY_W  = DATA_W + 3;
    localparam int ADC_W    = 14;
    localparam int REAL_MSB = 37;
    localparam int IMAG_MSB = 21;
    localparam int EXP_MSB  = 5;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        ABORT   = 2'd2
    } state_t;

    // Flipping the MSB recentres offset binary on zero; the result is then sign-extended.
    function automatic logic [15:0] ob14_to_tc16(input logic [ADC_W-1:0] x);
        return {{3{~x[13]}}, x[12:0]};
    endfunction

endpackage

// File: rtl/ofdm_adc_capture_if.sv
// Avalon-ST source bus carrying packed complex beats out of the capture block.
interface ofdm_adc_capture_if;
    import ofdm_pkg::*;

    logic [DATA_W-1:0] data;
    logic              valid;
    logic              ready;
    logic              startofpacket;
    logic              endofpacket;
    logic              error;

    modport master (output data, valid, startofpacket, endofpacket, error, input ready);
    modport slave  (input data, valid, startofpacket, endofpacket, error, output ready);
endinterface

// File: rtl/ofdm_adc_capture_fifo.sv
// Synchronous first-word-fall-through FIFO with a registered head; a written entry
// spends one cycle in storage before it can be presented.
module ofdm_stream_fifo #(
    parameter int WIDTH = 41,
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    mem_cnt;
    logic             head_valid;
    logic [WIDTH-1:0] head;
    logic             push;
    logic             pop;
    logic             load;

    // count covers storage plus head, so full is judged on registered state only
    assign count   = mem_cnt + CW'(head_valid);
    assign full    = (count == CW'(DEPTH));
    assign empty   = ~head_valid;
    assign rd_data = head;
    assign push    = wr_en && !full;
    assign pop     = head_valid && rd_en;
    assign load    = (mem_cnt != '0) && (!head_valid || pop);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            mem_cnt    <= '0;
            head_valid <= 1'b0;
            head       <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (load) begin
                head   <= mem[rd_ptr];
                rd_ptr <= rd_ptr + AW'(1);
            end
            head_valid <= load ? 1'b1 : (pop ? 1'b0 : head_valid);
            mem_cnt    <= mem_cnt + CW'(push) - CW'(load);
        end
    end

endmodule

// File: rtl/ofdm_adc_capture.sv
// Dual-channel ADC capture: converts offset-binary samples, frames them into packets
// and buffers beats for a backpressuring sink, closing aborted frames cleanly.
//
// state   | meaning
// IDLE    | no writes; waits for registered enable to start a frame
// CAPTURE | writes one sample per cycle, tracking frame position
// ABORT   | FIFO overran mid-frame; waits for room to write the error/eop close beat
module ofdm_adc_capture
    import ofdm_pkg::*;
#(
    parameter int FRAME_LEN  = 64,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                 sample_clock_adc,
    input  logic                 reset_reset,
    input  logic                 capture_enable,
    input  logic [ADC_W-1:0]     ADC_Capture_ChA_Data,
    input  logic [ADC_W-1:0]     ADC_Capture_ChB_Data,
    input  logic                 overflow_clear,
    output logic                 status_overflow,
    ofdm_adc_capture_if.master   aso_out0
);

    localparam int CNT_W = $clog2(FRAME_LEN);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_LEN - 1);

    logic               en_r;
    logic [ADC_W-1:0]   cha_r;
    logic [ADC_W-1:0]   chb_r;
    state_t             state;
    state_t             state_nx;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nx;
    logic               wr_en;
    logic [ENTRY_W-1:0] wr_entry;
    logic [DATA_W-1:0]  sample_word;
    logic               ovf_set;
    logic               fifo_full;
    logic               fifo_empty;
    logic [ENTRY_W-1:0] head;
    logic [LVL_W-1:0]   fifo_level_unused;

    always_ff @(posedge sample_clock_adc) begin
        if (!reset_reset) begin
            en_r  <= 1'b0;
            cha_r <= '0;
            chb_r <= '0;
        end else begin
            en_r  <= capture_enable;
            cha_r <= ADC_Capture_ChA_Data;
            chb_r <= ADC_Capture_ChB_Data;
        end
    end

    always_ff @(posedge sample_clock_adc) begin
        if (!reset_reset) begin
            state           <= IDLE;
            cnt             <= '0;
            status_overflow <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (ovf_set) begin
                status_overflow <= 1'b1;
            end else if (overflow_clear) begin
                status_overflow <= 1'b0;
            end
        end
    end

    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        wr_en       = 1'b0;
        wr_entry    = '0;
        ovf_set     = 1'b0;
        sample_word = '0;
        sample_word[REAL_MSB -: 16] = ob14_to_tc16(cha_r);
        sample_word[IMAG_MSB -: 16] = ob14_to_tc16(chb_r);
        sample_word[EXP_MSB:0]      = '0;

        unique case (state)
            IDLE: begin
                if (en_r) begin
                    state_nx = CAPTURE;
                    cnt_nx   = '0;
                end
            end
            CAPTURE: begin
                if (fifo_full) begin
                    // a drop at frame start leaves nothing open, so no close beat is owed
                    ovf_set  = 1'b1;
                    state_nx = (cnt == '0) ? IDLE : ABORT;
                end else begin
                    wr_en    = 1'b1;
                    wr_entry = {sample_word, cnt == '0, cnt == LAST, 1'b0};
                    cnt_nx   = cnt + CNT_W'(1);
                    if (cnt == LAST && !en_r) begin
                        state_nx = IDLE;
                    end
                end
            end
            ABORT: begin
                if (!fifo_full) begin
                    wr_en    = 1'b1;
                    wr_entry = {{DATA_W{1'b0}}, 1'b0, 1'b1, 1'b1};
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    ofdm_stream_fifo #(
        .WIDTH(ENTRY_W),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk    (sample_clock_adc),
        .rst_b  (reset_reset),
        .wr_en  (wr_en),
        .wr_data(wr_entry),
        .rd_en  (aso_out0.ready),
        .rd_data(head),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .count  (fifo_level_unused)
    );

    assign aso_out0.valid         = ~fifo_empty;
    assign aso_out0.data          = head[ENTRY_W-1:3];
    assign aso_out0.startofpacket = head[2];
    assign aso_out0.endofpacket   = head[1];
    assign aso_out0.error         = head[0];

endmodule

// File: tb/tb_ofdm_adc_capture.sv
// Directed and randomized bench for ofdm_adc_capture against a queue-based
// reference model of the capture/framing/FIFO behaviour.
module tb_ofdm_adc_capture;
    import ofdm_pkg::*;

    localparam int FL    = 8;
    localparam int DEPTH = 16;

    logic        clk   = 1'b0;
    logic        rst_b = 1'b0;
    logic        en    = 1'b0;
    logic        clr   = 1'b0;
    logic [13:0] cha   = '0;
    logic [13:0] chb   = '0;
    logic        ovf;

    ofdm_adc_capture_if bus();

    ofdm_adc_capture #(.FRAME_LEN(FL), .FIFO_DEPTH(DEPTH)) dut (
        .sample_clock_adc    (clk),
        .reset_reset         (rst_b),
        .capture_enable      (en),
        .ADC_Capture_ChA_Data(cha),
        .ADC_Capture_ChB_Data(chb),
        .overflow_clear      (clr),
        .status_overflow     (ovf),
        .aso_out0            (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [37:0] d;
        logic        s;
        logic        e;
        logic        r;
        int          t;
    } ent_t;

    int          checks   = 0;
    int          failures = 0;
    ent_t        q[$];
    logic [40:0] beats[$];
    logic [40:0] ref_beats[$];
    int          tnow = 0;
    bit          m_framing, m_close, m_ovf, exp_valid;
    int          m_pos;
    bit          s1_en;
    logic [13:0] s1_a, s1_b;
    bit          open_pkt;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] conv(input logic [13:0] x);
        int v;
        v = int'(x) - 8192;
        return v[15:0];
    endfunction

    function automatic logic [13:0] rnd14();
        return 14'($urandom);
    endfunction

    // Reference: the FIFO is a queue of beats; a beat can be presented once it has
    // been held for at least one cycle. Framing is tracked as a position in the frame.
    task automatic model_edge(input bit rdy, input bit e_in, input logic [13:0] a_in,
                              input logic [13:0] b_in, input bit c_in);
        bit full;
        bit dropped;
        logic [37:0] w;
        tnow++;
        if (!rst_b) begin
            q.delete();
            m_framing = 0; m_close = 0; m_pos = 0; m_ovf = 0;
            s1_en = 0; s1_a = '0; s1_b = '0; exp_valid = 0;
            return;
        end
        full    = (q.size() == DEPTH);
        dropped = 0;
        if (exp_valid && rdy) void'(q.pop_front());
        if (m_close) begin
            if (!full) begin
                q.push_back('{38'd0, 1'b0, 1'b1, 1'b1, tnow});
                m_close = 0;
            end
        end else if (m_framing) begin
            if (full) begin
                dropped   = 1;
                m_framing = 0;
                m_close   = (m_pos != 0);
            end else begin
                w = {conv(s1_a), conv(s1_b), 6'd0};
                q.push_back('{w, m_pos == 0, m_pos == FL - 1, 1'b0, tnow});
                m_pos = (m_pos + 1) % FL;
                if (m_pos == 0 && !s1_en) m_framing = 0;
            end
        end else if (s1_en) begin
            m_framing = 1;
            m_pos     = 0;
        end
        if (dropped) m_ovf = 1;
        else if (c_in) m_ovf = 0;
        s1_en = e_in; s1_a = a_in; s1_b = b_in;
        exp_valid = (q.size() > 0) && (q[0].t < tnow);
    endtask

    task automatic step(input bit rdy, input bit e_in, input logic [13:0] a_in,
                        input logic [13:0] b_in, input bit c_in);
        bus.ready = rdy; en = e_in; cha = a_in; chb = b_in; clr = c_in;
        if (rst_b && bus.valid && rdy) begin
            beats.push_back({bus.data, bus.startofpacket, bus.endofpacket, bus.error});
            if (bus.startofpacket) begin
                chk("sop_while_open", open_pkt, 1'b0);
                open_pkt = 1;
            end
            if (bus.endofpacket) begin
                chk("eop_while_closed", open_pkt, 1'b1);
                open_pkt = 0;
            end
        end
        if (!rst_b) open_pkt = 0;
        @(posedge clk);
        model_edge(rdy, e_in, a_in, b_in, c_in);
        #1;
        chk("valid", bus.valid, exp_valid);
        chk("status_overflow", ovf, m_ovf);
        if (exp_valid) begin
            chk("data", bus.data, q[0].d);
            chk("sop", bus.startofpacket, q[0].s);
            chk("eop", bus.endofpacket, q[0].e);
            chk("error", bus.error, q[0].r);
        end
        if (!rst_b) begin
            chk("rst_data", bus.data, 38'd0);
            chk("rst_sop", bus.startofpacket, 1'b0);
            chk("rst_eop", bus.endofpacket, 1'b0);
            chk("rst_error", bus.error, 1'b0);
        end
    endtask

    initial begin
        int first_v;
        int nerr;
        bit e;
        bus.ready = 1'b0;

        // reset with the ADC pins toggling
        rst_b = 1'b0;
        for (int j = 0; j < 3; j++) step(1'b1, 1'b1, rnd14(), rnd14(), 1'b0);
        rst_b = 1'b1;

        // conversion at the extremes and midscale
        for (int j = 0; j < 12; j++) begin
            step(1'b1, 1'b1, 14'h3FFF, 14'h0000, 1'b0);
            if (j < 3) chk("post_reset_valid", bus.valid, 1'b0);
        end
        chk("conv_valid", bus.valid, 1'b1);
        chk("conv_real_max", bus.data[37:22], 16'h1FFF);
        chk("conv_imag_min", bus.data[21:6], 16'hE000);
        chk("conv_exp", bus.data[5:0], 6'd0);
        for (int j = 0; j < 6; j++) step(1'b1, 1'b1, 14'h2000, rnd14(), 1'b0);
        chk("conv_real_mid", bus.data[37:22], 16'h0000);
        for (int j = 0; j < 16; j++) step(1'b1, 1'b0, 14'h2000, 14'h2000, 1'b0);

        // framing with a ramp, sink always ready
        beats.delete();
        first_v = -1;
        for (int j = 0; j < 40; j++) begin
            step(1'b1, j < 20, 14'(14'h2000 + j), 14'(j * 37 + 5), 1'b0);
            if (first_v < 0 && bus.valid) first_v = j;
        end
        chk("first_valid_latency", 64'(first_v), 64'd3);
        chk("frame_beats", 64'(beats.size()), 64'd24);
        for (int k = 0; k < beats.size(); k++) begin
            chk("ramp_real", beats[k][40:25], 16'(k + 1));
            chk("ramp_sop", beats[k][2], (k % FL) == 0);
            chk("ramp_eop", beats[k][1], (k % FL) == FL - 1);
        end
        ref_beats = beats;

        // same stimulus with the sink stalling every other cycle
        beats.delete();
        for (int j = 0; j < 70; j++)
            step(j % 2 == 0, j < 20, 14'(14'h2000 + j), 14'(j * 37 + 5), 1'b0);
        chk("bp_overflow", ovf, 1'b0);
        chk("bp_beats", 64'(beats.size()), 64'(ref_beats.size()));
        for (int k = 0; k < beats.size() && k < ref_beats.size(); k++)
            chk("bp_beat", beats[k], ref_beats[k]);

        // overrun in the middle of a frame
        beats.delete();
        for (int j = 0; j < 6; j++) step(1'b1, 1'b1, rnd14(), rnd14(), 1'b0);
        for (int j = 0; j < 30; j++) step(1'b0, 1'b1, rnd14(), rnd14(), 1'b0);
        chk("mid_overflow_set", ovf, 1'b1);
        for (int j = 0; j < 40; j++) step(1'b1, 1'b1, rnd14(), rnd14(), 1'b0);
        for (int j = 0; j < 30; j++) step(1'b1, 1'b0, rnd14(), rnd14(), 1'b0);
        nerr = 0;
        for (int k = 0; k < beats.size(); k++) begin
            if (beats[k][0]) begin
                nerr++;
                chk("abort_data", beats[k][40:3], 38'd0);
                chk("abort_sop", beats[k][2], 1'b0);
                chk("abort_eop", beats[k][1], 1'b1);
                if (k + 1 < beats.size()) chk("sop_after_abort", beats[k + 1][2], 1'b1);
            end
        end
        chk("abort_count", 64'(nerr), 64'd1);
        step(1'b1, 1'b0, rnd14(), rnd14(), 1'b1);
        chk("overflow_cleared", ovf, 1'b0);

        // overrun exactly at a frame boundary
        beats.delete();
        for (int j = 0; j < 30; j++) step(1'b0, 1'b1, rnd14(), rnd14(), 1'b0);
        chk("edge_overflow_set", ovf, 1'b1);
        for (int j = 0; j < 20; j++) step(1'b1, 1'b1, rnd14(), rnd14(), 1'b0);
        for (int j = 0; j < 30; j++) step(1'b1, 1'b0, rnd14(), rnd14(), 1'b0);
        nerr = 0;
        for (int k = 0; k < beats.size(); k++) if (beats[k][0]) nerr++;
        chk("edge_no_error_beat", 64'(nerr), 64'd0);
        chk("edge_whole_frames", 64'(beats.size() % FL), 64'd0);
        step(1'b1, 1'b0, rnd14(), rnd14(), 1'b1);

        // randomized traffic
        e = 1'b1;
        for (int j = 0; j < 400; j++) begin
            if ($urandom_range(0, 15) == 0) e = ~e;
            step($urandom_range(0, 3) != 0, e, rnd14(), rnd14(), $urandom_range(0, 31) == 0);
        end
        for (int j = 0; j < 40; j++) step(1'b1, 1'b0, rnd14(), rnd14(), 1'b0);

        // reset in the middle of a packet flushes the stream
        for (int j = 0; j < 12; j++) step(1'b1, 1'b1, rnd14(), rnd14(), 1'b0);
        rst_b = 1'b0;
        for (int j = 0; j < 2; j++) step(1'b1, 1'b1, rnd14(), rnd14(), 1'b0);
        rst_b = 1'b1;
        for (int j = 0; j < 30; j++) step(1'b1, j < 10, rnd14(), rnd14(), 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ofdm_adc_capture.md
Name: ofdm_adc_capture

Overview:
Receive-side counterpart of the OFDM DAC output stage. Captures dual-channel 14-bit offset-binary ADC samples every clock (ChA = real, ChB = imag) and converts them to 16-bit two's complement. Packs them into 38-bit Avalon-ST beats using the same word layout the DAC path consumes, framed into FRAME_LEN-sample packets. Buffers beats in a small FIFO so the downstream FFT/sync chain can apply backpressure. Overflow handling always leaves packets well-formed.

Parameters:
FRAME_LEN, 64, samples per packet (power of 2, 8..1024)
FIFO_DEPTH, 16, FIFO entries (power of 2, >=4)

Ports:
sample_clock_adc  in  1  sample clock; all logic on rising edge
reset_reset  in  1  synchronous, active-low reset
capture_enable  in  1  level; start/continue framing
ADC_Capture_ChA_Data  in  14  real sample, offset binary
ADC_Capture_ChB_Data  in  14  imag sample, offset binary
aso_out0_data  out  38  [37:22] real, [21:6] imag (two's complement), [5:0] BFP exponent = 0
aso_out0_valid  out  1  beat valid
aso_out0_ready  in  1  sink ready
aso_out0_startofpacket  out  1  first beat of frame
aso_out0_endofpacket  out  1  last beat of frame
aso_out0_error  out  1  set on forced-close beat of aborted frame
overflow_clear  in  1  clears status_overflow
status_overflow  out  1  sticky; FIFO overrun occurred

Behaviour:
- Reset (reset_reset==0 at edge): state IDLE, FIFO empty, sample counter 0, all outputs 0 (data, valid, sop, eop, error, status_overflow).
- Stage 1: ADC pins and capture_enable registered every cycle. Conversion: x16 = sign-extend({~x[13], x[12:0]}) to 16 bits; 0x2000 -> 0x0000, 0x3FFF -> 0x1FFF, 0x0000 -> 0xE000.
- Stage 2: FSM decides the FIFO write. Entry = {data38, sop, eop, error}.
- Latency: sample on pins at edge N appears on aso_out0 at edge N+3 earliest (register, write, FWFT output register).
- FSM states:
  - IDLE: no writes. If registered enable==1, go to CAPTURE with count=0.
  - CAPTURE: write each sample; sop=(count==0), eop=(count==FRAME_LEN-1). Count wraps to 0 after FRAME_LEN-1. At the wrap, if registered enable==0 go to IDLE, else stay in CAPTURE. Deasserting enable mid-frame always completes the frame.
  - ABORT: no sample writes. When FIFO not full, write {data=0, sop=0, eop=1, error=1}, then go to IDLE.
- Full = registered count==FIFO_DEPTH. A same-cycle read does not make room for a write.
- Write attempted in CAPTURE while full:
  - Sample dropped; status_overflow<=1.
  - If count==0, no packet is open: go to IDLE.
  - Otherwise go to ABORT.
- Output side: aso_out0_valid = FIFO not empty. Head entry is held stable while valid && !ready. Entry pops on valid && ready.
- status_overflow: set has priority over overflow_clear in the same cycle.
- Invariant: every sop beat is eventually followed by exactly one eop beat before the next sop.
- Reset mid-packet: FIFO contents discarded; no eop is emitted for the truncated packet. The sink must treat reset as a stream flush.

Decomposition:
- Package ofdm_pkg: DATA_W=38, field offsets (REAL_MSB=37, IMAG_MSB=21, EXP_MSB=5), state enum {IDLE, CAPTURE, ABORT}, function ob14_to_tc16.
- Sub-module: ofdm_stream_fifo (sync FWFT FIFO, width 41, depth FIFO_DEPTH, full/empty/count outputs). Reusable on the DAC side.

Test Plan:
- Reset: hold reset_reset=0 for 3 cycles with ADC toggling -> all outputs 0; valid stays 0 for at least 3 cycles after release.
- Conversion: ready=1, enable=1, ChA=0x3FFF, ChB=0x0000 -> beats with data[37:22]=0x1FFF, [21:6]=0xE000, [5:0]=0. Also ChA=0x2000 -> real 0x0000.
- Framing: FRAME_LEN=8, ready=1, ChA ramp 0x2000+i, enable high 20 cycles -> sop on beats 0,8,16; eop on 7,15,23. 24 beats total; the third frame completes after enable drops. First valid 3 cycles after first enabled sample.
- Backpressure: ready toggled 1/0 every cycle, FRAME_LEN=8, FIFO_DEPTH=16 -> no overflow; data and sop/eop identical to the ready=1 run. Head beat held stable during stalls.
- Overflow mid-frame: ready=0 with enable=1 until full -> status_overflow=1. After ready=1: partial frame ends with a beat of data=0, eop=1, error=1; next packet starts with sop. overflow_clear then drops status_overflow.
- Overflow at frame start: fill FIFO exactly so the drop hits count==0 -> no error beat; FSM goes to IDLE and restarts with sop once not full.
